// File: rtl/data_store_buffer.sv
// data_store_buffer: circular store buffer between a core data port and a
// backing RAM. Stores are queued and drained in program order over a
// req/ack write port. Loads forward from the youngest matching queued store,
// otherwise they return the RAM read data.
module data_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_ce_i,
    input  logic          core_we_i,
    input  logic [31:0]   core_addr_i,
    input  logic [31:0]   core_wdata_i,
    output logic [31:0]   core_rdata_o,
    output logic [31:0]   mem_raddr_o,
    input  logic [31:0]   mem_rdata_i,
    output logic          mem_wreq_o,
    output logic [31:0]   mem_waddr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic          mem_wack_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic          overflow_o
);

    localparam int PW = $clog2(DEPTH);

    // Entry storage holds only word addresses; byte offset bits are not kept.
    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          full, empty;
    logic          store_req, push, pop, drop;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [PW-1:0] fwd_idx;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Nothing moves while reset is asserted. A pop frees a slot in the same
    // cycle, so a store into a full buffer is accepted when the head drains.
    assign pop       = rst & ~empty & mem_wack_i;
    assign store_req = rst & core_ce_i & core_we_i;
    assign push      = store_req & (~full | pop);
    assign drop      = store_req & full & ~pop;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        ovf_d = ovf_q | drop;
    end

    // Control state: synchronous active-low reset empties the buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry payload written at the tail; validity comes from head/count only.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= core_addr_i[31:2];
            data_q[tail_q] <= core_wdata_i;
        end
    end

    // Scan oldest to youngest so the last match (youngest store) wins,
    // including the head entry that may be popping this cycle.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[fwd_idx] == core_addr_i[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    assign core_rdata_o = (core_ce_i && !core_we_i) ? (fwd_hit ? fwd_data : mem_rdata_i) : 32'h0;
    assign mem_raddr_o  = core_addr_i;

    // Drain port is gated by occupancy so it reads zero whenever empty.
    assign mem_wreq_o  = ~empty;
    assign mem_waddr_o = empty ? 32'h0 : {addr_q[head_q], 2'b00};
    assign mem_wdata_o = empty ? 32'h0 : data_q[head_q];

    assign full_o     = full;
    assign empty_o    = empty;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_data_store_buffer.sv
module tb_data_store_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_ce_i, core_we_i;
    logic [31:0]   core_addr_i, core_wdata_i, core_rdata_o;
    logic [31:0]   mem_raddr_o, mem_rdata_i;
    logic          mem_wreq_o;
    logic [31:0]   mem_waddr_o, mem_wdata_o;
    logic          mem_wack_i;
    logic          full_o, empty_o, overflow_o;
    logic [CW-1:0] count_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ld_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    data_store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .core_ce_i(core_ce_i), .core_we_i(core_we_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_rdata_o(core_rdata_o),
        .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i),
        .mem_wreq_o(mem_wreq_o), .mem_waddr_o(mem_waddr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wack_i(mem_wack_i),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Backing RAM model: read data is a fixed function of the address.
    assign mem_rdata_i = mem_raddr_o ^ 32'hCAFE_0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: loads compared against queued expectations, drained writes
    // compared in order on each accepted handshake.
    always @(negedge clk) begin
        if (core_ce_i && !core_we_i) begin
            if (ld_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL load_unexpected: got %h expected none", core_rdata_o);
            end else begin
                chk("load_data", core_rdata_o, ld_q.pop_front());
            end
        end
        if (rst && mem_wreq_o && mem_wack_i) begin
            if (wa_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL drain_unexpected: got %h expected none", mem_waddr_o);
            end else begin
                chk("drain_addr", mem_waddr_o, wa_q.pop_front());
                chk("drain_data", mem_wdata_o, wd_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic ce, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic ack);
        core_ce_i = ce; core_we_i = we; core_addr_i = a; core_wdata_i = d; mem_wack_i = ack;
        @(posedge clk); #1;
        core_ce_i = 1'b0; core_we_i = 1'b0; core_addr_i = '0; core_wdata_i = '0; mem_wack_i = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic ack, input bit expect_drain);
        if (expect_drain) begin
            wa_q.push_back(a);
            wd_q.push_back(d);
        end
        cyc(1'b1, 1'b1, a, d, ack);
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] exp, input logic ack);
        ld_q.push_back(exp);
        cyc(1'b1, 1'b0, a, 32'h0, ack);
    endtask

    task automatic idle(input logic ack);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, ack);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        core_ce_i = 0; core_we_i = 0; core_addr_i = 0; core_wdata_i = 0; mem_wack_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_wreq", 32'(mem_wreq_o), 32'd0);
        chk("rst_waddr", mem_waddr_o, 32'h0);
        chk("rst_wdata", mem_wdata_o, 32'h0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rdata_idle", core_rdata_o, 32'h0);
        rst = 1'b1;
        idle(1'b0);

        // Single store then forwarded load, then drain.
        st(32'h100, 32'hDEADBEEF, 1'b0, 1'b1);
        chk("st_wreq", 32'(mem_wreq_o), 32'd1);
        chk("st_waddr", mem_waddr_o, 32'h100);
        chk("st_count", 32'(count_o), 32'd1);
        ld(32'h100, 32'hDEADBEEF, 1'b0);
        chk("st_wreq_hold", 32'(mem_wreq_o), 32'd1);
        idle(1'b1);
        chk("st_drained", 32'(empty_o), 32'd1);

        // Two stores to one word: youngest forwarded, including while popping.
        st(32'h10, 32'h1, 1'b0, 1'b1);
        st(32'h10, 32'h2, 1'b0, 1'b1);
        ld(32'h10, 32'h2, 1'b0);
        ld(32'h10, 32'h2, 1'b1);
        chk("same_count1", 32'(count_o), 32'd1);
        ld(32'h10, 32'h2, 1'b1);
        chk("same_empty", 32'(empty_o), 32'd1);
        ld(32'h10, 32'hCAFE0010, 1'b0);
        // Store data while core_we_i=1 never leaks onto core_rdata_o.
        core_ce_i = 1; core_we_i = 1; core_addr_i = 32'h10; core_wdata_i = 32'h55;
        #1;
        chk("rdata_store", core_rdata_o, 32'h0);
        core_ce_i = 0; core_we_i = 0;
        idle(1'b0);

        // Fill, overflow, drain in order.
        st(32'h200, 32'hA0, 1'b0, 1'b1);
        st(32'h204, 32'hA1, 1'b0, 1'b1);
        st(32'h208, 32'hA2, 1'b0, 1'b1);
        chk("fill_notfull", 32'(full_o), 32'd0);
        st(32'h20C, 32'hA3, 1'b0, 1'b1);
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_noovf", 32'(overflow_o), 32'd0);
        st(32'h210, 32'hA4, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow_o), 32'd1);
        chk("ovf_count", 32'(count_o), 32'd4);
        ld(32'h210, 32'hCAFE0210, 1'b0);
        repeat (4) idle(1'b1);
        chk("ovf_empty", 32'(empty_o), 32'd1);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
        rst = 1'b0;
        idle(1'b0);
        rst = 1'b1;
        chk("ovf_cleared", 32'(overflow_o), 32'd0);

        // Full buffer with simultaneous push and pop.
        st(32'h300, 32'hB0, 1'b0, 1'b1);
        st(32'h304, 32'hB1, 1'b0, 1'b1);
        st(32'h308, 32'hB2, 1'b0, 1'b1);
        st(32'h30C, 32'hB3, 1'b0, 1'b1);
        st(32'h310, 32'hB4, 1'b1, 1'b1);
        chk("pp_count", 32'(count_o), 32'd4);
        chk("pp_full", 32'(full_o), 32'd1);
        chk("pp_noovf", 32'(overflow_o), 32'd0);
        chk("pp_head", mem_waddr_o, 32'h304);
        repeat (4) idle(1'b1);
        chk("pp_empty", 32'(empty_o), 32'd1);

        // Eight stores streaming through: pointers wrap twice.
        for (int k = 0; k < 8; k++) begin
            st(32'h400 + 32'(4 * k), 32'hC0 + 32'(k), 1'b1, 1'b1);
        end
        idle(1'b1);
        chk("wrap_empty", 32'(empty_o), 32'd1);
        chk("wrap_noovf", 32'(overflow_o), 32'd0);

        // Reset while entries are pending and the RAM acknowledges.
        st(32'h500, 32'hD0, 1'b0, 1'b0);
        st(32'h504, 32'hD1, 1'b0, 1'b0);
        st(32'h508, 32'hD2, 1'b0, 1'b0);
        chk("mrst_pend", 32'(count_o), 32'd3);
        rst = 1'b0;
        idle(1'b1);
        chk("mrst_wreq", 32'(mem_wreq_o), 32'd0);
        chk("mrst_count", 32'(count_o), 32'd0);
        chk("mrst_waddr", mem_waddr_o, 32'h0);
        rst = 1'b1;
        ld(32'h500, 32'hCAFE0500, 1'b1);
        idle(1'b0);

        chk("pending_loads", 32'(ld_q.size()), 32'd0);
        chk("pending_drains", 32'(wa_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
